// File: rtl/wb_regfile_if.sv
// rtl/wb_regfile_if.sv - writeback/read bus bundle between pipeline and register file
interface wb_regfile_if;
  logic [31:0] alu_out_wb;
  logic [31:0] mem_read_out;
  logic [4:0]  RegDst_out;
  logic        MemtoReg_out;
  logic        RegWrite_out;
  logic [4:0]  rs_addr;
  logic [4:0]  rt_addr;
  logic [31:0] rs_data;
  logic [31:0] rt_data;
  logic [31:0] wb_data;
  logic [31:0] wb_count;

  modport master (
    output alu_out_wb, mem_read_out, RegDst_out, MemtoReg_out, RegWrite_out,
    output rs_addr, rt_addr,
    input  rs_data, rt_data, wb_data, wb_count
  );

  modport slave (
    input  alu_out_wb, mem_read_out, RegDst_out, MemtoReg_out, RegWrite_out,
    input  rs_addr, rt_addr,
    output rs_data, rt_data, wb_data, wb_count
  );
endinterface

// File: rtl/wb_regfile.sv
// rtl/wb_regfile.sv - 32x32 register file with writeback mux, write-to-read bypass and commit counter
module wb_regfile (
  input  logic        clk,
  input  logic        reset,
  wb_regfile_if.slave bus
);
  logic [31:0] regs_q [32];
  logic [31:0] regs_d [32];
  logic [31:0] count_q;
  logic [31:0] count_d;
  logic [31:0] wb_sel;
  logic        wr_en;
  logic        commit;

  assign wb_sel = bus.MemtoReg_out ? bus.mem_read_out : bus.alu_out_wb;
  assign wr_en  = bus.RegWrite_out && (bus.RegDst_out != 5'd0);
  assign commit = wr_en && !reset;

  assign bus.wb_data  = wb_sel;
  assign bus.wb_count = count_q;

  // Bypass ignores reset so forwarding stays purely combinational.
  always_comb begin
    bus.rs_data = 32'd0;
    bus.rt_data = 32'd0;
    if (bus.rs_addr != 5'd0) begin
      bus.rs_data = (wr_en && bus.rs_addr == bus.RegDst_out) ? wb_sel : regs_q[bus.rs_addr];
    end
    if (bus.rt_addr != 5'd0) begin
      bus.rt_data = (wr_en && bus.rt_addr == bus.RegDst_out) ? wb_sel : regs_q[bus.rt_addr];
    end
  end

  always_comb begin
    for (int i = 0; i < 32; i++) begin
      regs_d[i] = regs_q[i];
    end
    count_d = count_q;
    if (commit) begin
      regs_d[bus.RegDst_out] = wb_sel;
      count_d = count_q + 32'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < 32; i++) begin
        regs_q[i] <= 32'd0;
      end
      count_q <= 32'd0;
    end else begin
      for (int i = 0; i < 32; i++) begin
        regs_q[i] <= regs_d[i];
      end
      count_q <= count_d;
    end
  end
endmodule

// File: tb/tb_wb_regfile.sv
// tb/tb_wb_regfile.sv - directed and randomized checks of wb_regfile against a behavioural model
module tb_wb_regfile;
  logic clk;
  logic reset;
  wb_regfile_if bus ();

  wb_regfile dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  logic [31:0] mregs [32];
  logic [31:0] mcount;
  bit          mvalid = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] exp_wb();
    return bus.MemtoReg_out ? bus.mem_read_out : bus.alu_out_wb;
  endfunction

  function automatic logic [31:0] exp_read(input logic [4:0] a);
    if (a == 0) return 32'd0;
    if (bus.RegWrite_out && a == bus.RegDst_out) return exp_wb();
    return mregs[a];
  endfunction

  // Model: compare at negedge, then advance architectural state at posedge.
  initial begin
    forever begin
      @(negedge clk);
      if (mvalid) begin
        check("wb_data",  bus.wb_data,  exp_wb());
        check("rs_data",  bus.rs_data,  exp_read(bus.rs_addr));
        check("rt_data",  bus.rt_data,  exp_read(bus.rt_addr));
        check("wb_count", bus.wb_count, mcount);
      end
      @(posedge clk);
      if (reset) begin
        for (int i = 0; i < 32; i++) mregs[i] = 32'd0;
        mcount = 32'd0;
        mvalid = 1'b1;
      end else if (mvalid && bus.RegWrite_out && bus.RegDst_out != 0) begin
        mregs[bus.RegDst_out] = exp_wb();
        mcount = mcount + 32'd1;
      end
    end
  end

  task automatic drive(input bit rst, input bit rw, input logic [4:0] dst, input bit m2r,
                       input logic [31:0] alu, input logic [31:0] mem,
                       input logic [4:0] rs, input logic [4:0] rt);
    reset             = rst;
    bus.RegWrite_out  = rw;
    bus.RegDst_out    = dst;
    bus.MemtoReg_out  = m2r;
    bus.alu_out_wb    = alu;
    bus.mem_read_out  = mem;
    bus.rs_addr       = rs;
    bus.rt_addr       = rt;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    drive(1, 0, 0, 0, 0, 0, 0, 0);
    step();
    step();

    for (int i = 0; i < 32; i++) begin
      drive(0, 0, 0, 0, 0, 0, 5'(i), 5'(31 - i));
      @(negedge clk);
      check("reset_rs", bus.rs_data, 32'd0);
      check("reset_rt", bus.rt_data, 32'd0);
      check("reset_cnt", bus.wb_count, 32'd0);
      step();
    end

    drive(0, 1, 5, 0, 32'h12345678, 32'h0, 5, 0);
    @(negedge clk);
    check("r5_bypass", bus.rs_data, 32'h12345678);
    step();
    drive(0, 0, 0, 0, 0, 0, 5, 0);
    @(negedge clk);
    check("r5_stored", bus.rs_data, 32'h12345678);
    check("cnt_after_r5", bus.wb_count, 32'd1);
    step();

    drive(0, 1, 0, 1, 32'h1, 32'hDEADBEEF, 0, 0);
    @(negedge clk);
    check("r0_wb_data", bus.wb_data, 32'hDEADBEEF);
    check("r0_read", bus.rs_data, 32'd0);
    step();
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    @(negedge clk);
    check("r0_cnt", bus.wb_count, 32'd1);
    step();

    drive(0, 1, 7, 0, 32'hA, 0, 7, 7);
    @(negedge clk);
    check("r7_a_rs", bus.rs_data, 32'hA);
    check("r7_a_rt", bus.rt_data, 32'hA);
    step();
    drive(0, 1, 7, 0, 32'hB, 0, 7, 7);
    @(negedge clk);
    check("r7_b_rs", bus.rs_data, 32'hB);
    check("r7_b_rt", bus.rt_data, 32'hB);
    step();
    drive(0, 0, 0, 0, 0, 0, 7, 7);
    @(negedge clk);
    check("r7_st_rs", bus.rs_data, 32'hB);
    check("r7_st_rt", bus.rt_data, 32'hB);
    check("r7_cnt", bus.wb_count, 32'd3);
    step();

    drive(1, 1, 3, 0, 32'h55, 0, 3, 5);
    step();
    drive(0, 0, 0, 0, 0, 0, 3, 5);
    @(negedge clk);
    check("r3_after_rst", bus.rs_data, 32'd0);
    check("r5_after_rst", bus.rt_data, 32'd0);
    check("cnt_after_rst", bus.wb_count, 32'd0);
    step();

    force dut.count_q = 32'hFFFFFFFF;
    mcount = 32'hFFFFFFFF;
    #1;
    release dut.count_q;
    drive(0, 1, 9, 0, 32'h1, 0, 9, 0);
    @(negedge clk);
    check("cnt_preload", bus.wb_count, 32'hFFFFFFFF);
    step();
    drive(0, 0, 0, 0, 0, 0, 9, 0);
    @(negedge clk);
    check("cnt_wrap", bus.wb_count, 32'd0);
    check("r9_stored", bus.rs_data, 32'h1);
    step();

    for (int n = 0; n < 3000; n++) begin
      logic [4:0] dst;
      logic [4:0] rs;
      logic [4:0] rt;
      dst = 5'($urandom_range(0, 31));
      rs  = ($urandom_range(0, 3) == 0) ? dst : 5'($urandom_range(0, 31));
      rt  = ($urandom_range(0, 3) == 0) ? dst : 5'($urandom_range(0, 31));
      drive($urandom_range(0, 49) == 0, $urandom_range(0, 2) != 0, dst,
            1'($urandom_range(0, 1)), $urandom, $urandom, rs, rt);
      step();
    end

    @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
